// File: rtl/dmem_mmio_resp.sv
// dmem_mmio_resp: MMIO responder sharing the data-memory port.
// Claims an 8-word window at BASE_ADDR: ID, scratch, CTRL, STATUS,
// push/pop FIFO, 48-bit cycle counter low word and counter snapshot.
// Read data is registered (one-cycle latency) like the data memory.
// Optional feature: define MMIO_IRQ_EN to add the or_irq output and CTRL bit3.

`ifndef HBIT_ADDR
`define HBIT_ADDR 47
`endif

module dmem_mmio_resp #(
    parameter logic [47:0] BASE_ADDR  = 48'hFFFF00,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [23:0] ID_VALUE   = 24'hA3B001
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    input  logic                 iw_we,
    input  logic                 iw_re,
    input  logic [`HBIT_ADDR:0]  iw_addr,
    input  logic [`HBIT_ADDR:0]  iw_wdata,
    input  logic                 iw_is48,
    output logic [`HBIT_ADDR:0]  or_rdata,
    output logic                 or_hit
`ifdef MMIO_IRQ_EN
    ,
    output logic                 or_irq
`endif
);

    localparam int unsigned AW = `HBIT_ADDR + 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        OFF_ID      = 3'd0,
        OFF_SCRATCH = 3'd1,
        OFF_CTRL    = 3'd2,
        OFF_STATUS  = 3'd3,
        OFF_FIFO    = 3'd4,
        OFF_CNT_LO  = 3'd5,
        OFF_CNT_HI  = 3'd6,
        OFF_RSVD    = 3'd7
    } reg_off_e;

    // registered state
    logic [AW-1:0] rdata_q, rdata_d;
    logic          hit_q, hit_d;
    logic [23:0]   scratch_q, scratch_d;
    logic          ctrl_en_q, ctrl_en_d;
    logic [23:0]   fifo_mem_q [FIFO_DEPTH];
    logic [23:0]   fifo_mem_d [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [47:0]   cnt_q, cnt_d;
    logic [23:0]   snap_q, snap_d;
`ifdef MMIO_IRQ_EN
    logic          irq_en_q, irq_en_d;
    logic          irq_q, irq_d;
`endif

    // decode / combinational helpers
    logic          hit;
    reg_off_e      off;
    logic          wr, rd;
    logic          push, pop, ctrl_wr, clr_cnt, flush, stat_wr, snap_take;
    logic          fifo_empty, fifo_full;
    logic [4:0]    count5;
    logic [AW-1:0] rd_val;
    logic          unused_wdata_hi;

    // address decode and access strobes
    always_comb begin
        hit             = (iw_addr[AW-1:3] == BASE_ADDR[AW-1:3]);
        off             = reg_off_e'(iw_addr[2:0]);
        wr              = iw_we & hit;
        rd              = iw_re & hit;
        push            = wr && (off == OFF_FIFO);
        pop             = rd && (off == OFF_FIFO);
        ctrl_wr         = wr && (off == OFF_CTRL);
        clr_cnt         = ctrl_wr & iw_wdata[1];
        flush           = ctrl_wr & iw_wdata[2];
        stat_wr         = wr && (off == OFF_STATUS);
        snap_take       = rd && (off == OFF_CNT_LO) && !iw_is48;
        fifo_empty      = (count_q == '0);
        fifo_full       = (count_q == CW'(FIFO_DEPTH));
        count5          = '0;
        count5[CW-1:0]  = count_q;
        unused_wdata_hi = ^iw_wdata[AW-1:24];
    end

    // read mux over the current register contents
    always_comb begin
        rd_val = '0;
        case (off)
            OFF_ID:      rd_val[23:0] = ID_VALUE;
            OFF_SCRATCH: rd_val[23:0] = scratch_q;
            OFF_CTRL: begin
                rd_val[0] = ctrl_en_q;
`ifdef MMIO_IRQ_EN
                rd_val[3] = irq_en_q;
`endif
            end
            OFF_STATUS:  rd_val[8:0] = {unf_q, ovf_q, fifo_full, fifo_empty, count5};
            OFF_FIFO:    rd_val[23:0] = fifo_empty ? 24'd0 : fifo_mem_q[rd_ptr_q];
            OFF_CNT_LO:  rd_val = iw_is48 ? cnt_q : {24'd0, cnt_q[23:0]};
            OFF_CNT_HI:  rd_val[23:0] = snap_q;
            OFF_RSVD:    rd_val = '0;
            default:     rd_val = '0;
        endcase
    end

    // next-state for registers, counter and FIFO
    always_comb begin
        rdata_d    = hit ? rd_val : '0;
        hit_d      = hit;
        scratch_d  = scratch_q;
        ctrl_en_d  = ctrl_en_q;
        fifo_mem_d = fifo_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        snap_d     = snap_q;
`ifdef MMIO_IRQ_EN
        irq_en_d   = irq_en_q;
        irq_d      = irq_en_q & (!fifo_empty | ovf_q);
`endif

        if (wr && (off == OFF_SCRATCH)) scratch_d = iw_wdata[23:0];
        if (ctrl_wr) begin
            ctrl_en_d = iw_wdata[0];
`ifdef MMIO_IRQ_EN
            irq_en_d  = iw_wdata[3];
`endif
        end

        // clear beats increment; the enable in effect is the pre-write one
        if (clr_cnt)        cnt_d = '0;
        else if (ctrl_en_q) cnt_d = cnt_q + 48'd1;
        else                cnt_d = cnt_q;

        if (snap_take) snap_d = cnt_q[47:24];

        // sticky clears first so a same-cycle set below wins
        if (stat_wr) begin
            if (iw_wdata[7]) ovf_d = 1'b0;
            if (iw_wdata[8]) unf_d = 1'b0;
        end

        // simultaneous push/pop at full: overwriting the old head slot is
        // safe because the popped value was already captured in rdata_d
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (push && pop) begin
            fifo_mem_d[wr_ptr_q] = iw_wdata[23:0];
            wr_ptr_d             = wr_ptr_q + PW'(1);
            if (fifo_empty) begin
                unf_d   = 1'b1;
                count_d = CW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end else if (push) begin
            if (fifo_full) begin
                ovf_d = 1'b1;
            end else begin
                fifo_mem_d[wr_ptr_q] = iw_wdata[23:0];
                wr_ptr_d             = wr_ptr_q + PW'(1);
                count_d              = count_q + CW'(1);
            end
        end else if (pop) begin
            if (fifo_empty) begin
                unf_d = 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                count_d  = count_q - CW'(1);
            end
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            rdata_q    <= '0;
            hit_q      <= 1'b0;
            scratch_q  <= '0;
            ctrl_en_q  <= 1'b0;
            fifo_mem_q <= '{default: '0};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            cnt_q      <= '0;
            snap_q     <= '0;
`ifdef MMIO_IRQ_EN
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
`endif
        end else begin
            rdata_q    <= rdata_d;
            hit_q      <= hit_d;
            scratch_q  <= scratch_d;
            ctrl_en_q  <= ctrl_en_d;
            fifo_mem_q <= fifo_mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
`ifdef MMIO_IRQ_EN
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
`endif
        end
    end

    assign or_rdata = rdata_q;
    assign or_hit   = hit_q;
`ifdef MMIO_IRQ_EN
    assign or_irq   = irq_q;
`endif

endmodule

// File: tb/tb_dmem_mmio_resp.sv
// Testbench for dmem_mmio_resp: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the register window.

`timescale 1ns/1ps

module tb_dmem_mmio_resp;

    localparam logic [47:0] BASE  = 48'hFFFF00;
    localparam int          DEPTH = 4;
    localparam logic [23:0] IDV   = 24'hA3B001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0, re = 1'b0, is48 = 1'b0;
    logic [47:0] addr = '0, wdata = '0;
    logic [47:0] rdata;
    logic        hit;
`ifdef MMIO_IRQ_EN
    logic        irq;
`endif

    dmem_mmio_resp #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(DEPTH),
        .ID_VALUE  (IDV)
    ) dut (
        .iw_clk  (clk),
        .iw_rst  (rst),
        .iw_we   (we),
        .iw_re   (re),
        .iw_addr (addr),
        .iw_wdata(wdata),
        .iw_is48 (is48),
        .or_rdata(rdata),
        .or_hit  (hit)
`ifdef MMIO_IRQ_EN
        ,
        .or_irq  (irq)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [23:0] mq[$];
    logic [23:0] m_scratch, m_snap;
    logic        m_en, m_ovf, m_unf, m_irqen;
    logic [47:0] m_cnt;
    logic [47:0] exp_rdata;
    logic        exp_hit;

    task automatic model_reset();
        mq.delete();
        m_scratch = '0; m_snap = '0; m_en = 0; m_ovf = 0; m_unf = 0;
        m_irqen = 0; m_cnt = '0;
    endtask

    function automatic logic [47:0] m_read(input logic [2:0] o, input logic w48);
        logic [47:0] v;
        v = '0;
        case (o)
            3'd0: v[23:0] = IDV;
            3'd1: v[23:0] = m_scratch;
            3'd2: begin
                v[0] = m_en;
`ifdef MMIO_IRQ_EN
                v[3] = m_irqen;
`endif
            end
            3'd3: begin
                v = 48'(mq.size());
                if (mq.size() == 0)     v = v + 48'h20;
                if (mq.size() == DEPTH) v = v + 48'h40;
                if (m_ovf)              v = v + 48'h80;
                if (m_unf)              v = v + 48'h100;
            end
            3'd4: if (mq.size() != 0) v[23:0] = mq[0];
            3'd5: v = w48 ? m_cnt : {24'd0, m_cnt[23:0]};
            3'd6: v[23:0] = m_snap;
            default: v = '0;
        endcase
        return v;
    endfunction

    // one bus cycle: predict the registered response, advance the model,
    // clock the DUT; outputs are valid for checking on return
    task automatic acc(input logic a_we, input logic a_re, input logic [47:0] a_addr,
                       input logic [47:0] a_wd, input logic a_48);
        logic        h, w, r;
        logic [2:0]  o;
        logic [23:0] d;
        logic [47:0] ncnt;
        we = a_we; re = a_re; addr = a_addr; wdata = a_wd; is48 = a_48;
        h = (a_addr[47:3] == BASE[47:3]);
        o = a_addr[2:0];
        d = a_wd[23:0];
        w = a_we & h;
        r = a_re & h;
        exp_hit   = h;
        exp_rdata = h ? m_read(o, a_48) : 48'd0;
        if (w && o == 3'd2 && a_wd[1]) ncnt = '0;
        else                           ncnt = m_en ? m_cnt + 48'd1 : m_cnt;
        if (r && o == 3'd5 && !a_48) m_snap = m_cnt[47:24];
        if (w && o == 3'd1) m_scratch = d;
        if (w && o == 3'd3) begin
            if (a_wd[7]) m_ovf = 0;
            if (a_wd[8]) m_unf = 0;
        end
        if (w && o == 3'd2 && a_wd[2]) mq.delete();
        else if (w && r && o == 3'd4) begin
            if (mq.size() == 0) begin
                mq.push_back(d);
                m_unf = 1;
            end else begin
                void'(mq.pop_front());
                mq.push_back(d);
            end
        end else if (w && o == 3'd4) begin
            if (mq.size() == DEPTH) m_ovf = 1;
            else                    mq.push_back(d);
        end else if (r && o == 3'd4) begin
            if (mq.size() == 0) m_unf = 1;
            else                void'(mq.pop_front());
        end
        if (w && o == 3'd2) begin
            m_en    = a_wd[0];
            m_irqen = a_wd[3];
        end
        m_cnt = ncnt;
        @(posedge clk); #1;
        we = 0; re = 0; is48 = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) acc(0, 0, 48'd0, 48'd0, 0);
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
        n_cmp++;
        if ({hit, rdata} !== 49'd0) begin
            n_bad++; $display("FAIL reset_out: got hit=%b rdata=%h want 0/0", hit, rdata);
        end
        acc(0, 1, BASE + 3, 0, 0);
        n_cmp++;
        if (rdata !== 48'h20 || hit !== 1'b1) begin
            n_bad++; $display("FAIL reset_status: got %h hit=%b want 000000000020 hit=1", rdata, hit);
        end
    endtask

    task automatic test_id_scratch();
        acc(0, 1, BASE, 0, 0);
        n_cmp++;
        if (rdata !== {24'd0, IDV} || hit !== 1'b1) begin
            n_bad++; $display("FAIL id_read: got %h hit=%b want a3b001 hit=1", rdata, hit);
        end
        acc(1, 0, BASE + 1, 48'h123_5A5A5A, 0);
        acc(0, 1, BASE + 1, 0, 0);
        n_cmp++;
        if (rdata !== 48'h5A5A5A) begin
            n_bad++; $display("FAIL scratch_rw: got %h want 5a5a5a", rdata);
        end
        acc(0, 1, BASE + 8, 0, 0);
        n_cmp++;
        if (hit !== 1'b0 || rdata !== 48'd0) begin
            n_bad++; $display("FAIL miss_read: got hit=%b rdata=%h want 0/0", hit, rdata);
        end
        acc(0, 1, BASE + 7, 0, 1);
        n_cmp++;
        if (hit !== 1'b1 || rdata !== 48'd0) begin
            n_bad++; $display("FAIL reserved_read: got hit=%b rdata=%h want 1/0", hit, rdata);
        end
    endtask

    task automatic test_fifo_fill();
        logic [23:0] vals [5];
        vals = '{24'h11, 24'h22, 24'h33, 24'h44, 24'h55};
        for (int i = 0; i < 5; i++) acc(1, 0, BASE + 4, {24'd0, vals[i]}, 0);
        acc(0, 1, BASE + 3, 0, 0);
        n_cmp++;
        if (rdata !== 48'hC4) begin
            n_bad++; $display("FAIL fill_status: got %h want 0c4", rdata);
        end
        for (int i = 0; i < 4; i++) begin
            acc(0, 1, BASE + 4, 0, 0);
            n_cmp++;
            if (rdata !== {24'd0, vals[i]}) begin
                n_bad++; $display("FAIL pop_%0d: got %h want %h", i, rdata, vals[i]);
            end
        end
        acc(0, 1, BASE + 4, 0, 0);
        n_cmp++;
        if (rdata !== 48'd0) begin
            n_bad++; $display("FAIL pop_empty: got %h want 0", rdata);
        end
        acc(0, 1, BASE + 3, 0, 0);
        n_cmp++;
        if (rdata !== 48'h1A0) begin
            n_bad++; $display("FAIL sticky_status: got %h want 1a0", rdata);
        end
        acc(1, 0, BASE + 3, 48'h180, 0);
        acc(0, 1, BASE + 3, 0, 0);
        n_cmp++;
        if (rdata !== 48'h20) begin
            n_bad++; $display("FAIL sticky_clear: got %h want 020", rdata);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) acc(1, 0, BASE + 4, 48'(i), 0);
        acc(1, 1, BASE + 4, 48'd5, 0);
        n_cmp++;
        if (rdata !== 48'd1) begin
            n_bad++; $display("FAIL pushpop_full_head: got %h want 1", rdata);
        end
        acc(0, 1, BASE + 3, 0, 0);
        n_cmp++;
        if (rdata !== 48'h44) begin
            n_bad++; $display("FAIL pushpop_full_status: got %h want 044", rdata);
        end
        for (int i = 2; i <= 5; i++) begin
            acc(0, 1, BASE + 4, 0, 0);
            n_cmp++;
            if (rdata !== 48'(i)) begin
                n_bad++; $display("FAIL pushpop_drain_%0d: got %h want %h", i, rdata, i);
            end
        end
        acc(1, 1, BASE + 4, 48'h9, 0);
        n_cmp++;
        if (rdata !== 48'd0) begin
            n_bad++; $display("FAIL pushpop_empty_data: got %h want 0", rdata);
        end
        acc(0, 1, BASE + 3, 0, 0);
        n_cmp++;
        if (rdata !== 48'h101) begin
            n_bad++; $display("FAIL pushpop_empty_status: got %h want 101", rdata);
        end
        acc(0, 1, BASE + 4, 0, 0);
        n_cmp++;
        if (rdata !== 48'h9) begin
            n_bad++; $display("FAIL pushpop_empty_pop: got %h want 9", rdata);
        end
        acc(1, 0, BASE + 3, 48'h180, 0);
    endtask

    task automatic test_counter();
        acc(1, 0, BASE + 2, 48'h3, 0);
        idle(10);
        acc(0, 1, BASE + 5, 0, 1);
        n_cmp++;
        if (rdata !== 48'd10) begin
            n_bad++; $display("FAIL cnt_delta: got %h want 10", rdata);
        end
        acc(0, 1, BASE + 2, 0, 0);
        n_cmp++;
        if (rdata !== 48'd1) begin
            n_bad++; $display("FAIL ctrl_readback: got %h want 1", rdata);
        end
        force dut.cnt_q = 48'hFFFF_FFFF_FFFF;
        #1 release dut.cnt_q;
        m_cnt = 48'hFFFF_FFFF_FFFF;
        acc(0, 1, BASE + 5, 0, 1);
        n_cmp++;
        if (rdata !== 48'hFFFF_FFFF_FFFF) begin
            n_bad++; $display("FAIL cnt_max: got %h want ffffffffffff", rdata);
        end
        acc(0, 1, BASE + 5, 0, 1);
        n_cmp++;
        if (rdata !== 48'd0) begin
            n_bad++; $display("FAIL cnt_wrap: got %h want 0", rdata);
        end
        idle(5);
        acc(1, 0, BASE + 2, 48'h3, 0);
        acc(0, 1, BASE + 5, 0, 1);
        n_cmp++;
        if (rdata !== 48'd0) begin
            n_bad++; $display("FAIL cnt_clear: got %h want 0", rdata);
        end
    endtask

    task automatic test_snapshot();
        force dut.cnt_q = 48'h000001_FFFFFF;
        #1 release dut.cnt_q;
        m_cnt = 48'h000001_FFFFFF;
        acc(0, 1, BASE + 5, 0, 0);
        n_cmp++;
        if (rdata !== 48'hFFFFFF) begin
            n_bad++; $display("FAIL snap_lo: got %h want ffffff", rdata);
        end
        idle(2);
        acc(0, 1, BASE + 6, 0, 0);
        n_cmp++;
        if (rdata !== 48'h1) begin
            n_bad++; $display("FAIL snap_hi: got %h want 000001", rdata);
        end
        acc(0, 1, BASE + 5, 0, 1);
        n_cmp++;
        if (rdata !== exp_rdata) begin
            n_bad++; $display("FAIL cnt_after_carry: got %h want %h", rdata, exp_rdata);
        end
    endtask

    task automatic test_reset_midop();
        acc(1, 0, BASE + 4, 48'hAA, 0);
        acc(1, 0, BASE + 4, 48'hBB, 0);
        re = 1; addr = BASE + 4; rst = 1;
        @(posedge clk); #1;
        re = 0; rst = 0;
        model_reset();
        n_cmp++;
        if (hit !== 1'b0 || rdata !== 48'd0) begin
            n_bad++; $display("FAIL midrst_out: got hit=%b rdata=%h want 0/0", hit, rdata);
        end
        acc(0, 1, BASE + 3, 0, 0);
        n_cmp++;
        if (rdata !== 48'h20) begin
            n_bad++; $display("FAIL midrst_status: got %h want 020", rdata);
        end
        acc(0, 1, BASE + 2, 0, 0);
        n_cmp++;
        if (rdata !== 48'd0) begin
            n_bad++; $display("FAIL midrst_ctrl: got %h want 0", rdata);
        end
        acc(0, 1, BASE + 5, 0, 1);
        n_cmp++;
        if (rdata !== 48'd0) begin
            n_bad++; $display("FAIL midrst_cnt: got %h want 0", rdata);
        end
    endtask

    task automatic test_random();
        logic [47:0] a, d;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) == 0) a = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            else                        a = BASE + 48'($urandom_range(7));
            d = {16'($urandom), $urandom};
            acc(1'($urandom), 1'($urandom), a, d, 1'($urandom));
            n_cmp++;
            if (rdata !== exp_rdata || hit !== exp_hit) begin
                n_bad++;
                $display("FAIL rand_%0d addr=%h: got hit=%b rdata=%h want hit=%b rdata=%h",
                         i, a, hit, rdata, exp_hit, exp_rdata);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_id_scratch();
        test_fifo_fill();
        test_back_to_back();
        test_counter();
        test_snapshot();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
